rf_wport_arbiter: RTL and testbench

//  Arbitrates the single regfile write port between the in-order WB stage and an
//  out-of-band long-latency producer (multi-cycle div / late load return).
//  WB always wins; side results are queued in a small FIFO and drained on WB idle

---
 rtl/rf_wport_arbiter.sv | 136 +++++++++++++
 tb/tb_rf_wport_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single regfile write port between the in-order
// WB stage and an out-of-band long-latency producer. WB always wins. Side
// results wait in a small FIFO and drain on WB idle cycles. A stall request
// forces a WB bubble when the FIFO is full or its head has waited too long.
//
// Handshake: a side result transfers on a rising clk edge where side_valid and
// side_ready are both 1. side_ready depends only on registered occupancy and
// rst, never on side_valid. Results addressed to r0 complete the handshake but
// are dropped.
module rf_wport_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [4:0]               wb_waddr,
    input  logic [31:0]              wb_wdata,
    input  logic                     side_valid,
    output logic                     side_ready,
    input  logic [4:0]               side_waddr,
    input  logic [31:0]              side_wdata,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     stallreq,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // FIFO storage. live_q marks entries not yet superseded by a younger WB
    // write to the same register; dead entries still drain, but write nothing.
    logic [4:0]        addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [DEPTH-1:0]  live_q, live_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic starved;

    // Occupancy flags and the push/pop decisions for this cycle.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        starved = (starve_q == SW'(STARVE_LIMIT));
        push    = side_valid & side_ready & (side_waddr != 5'd0);
        pop     = ~rst & ~wb_we & ~empty;
    end

    // Next-state for pointers, occupancy, starvation counter and live bits.
    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        starve_d = starve_q;
        if (pop || empty) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + SW'(1);
        end
        // A WB write kills older queued copies of its register; the entry
        // pushed this same cycle is younger, so it is set after the kill.
        live_d = live_q;
        if (wb_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == wb_waddr) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            live_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            live_q   <= live_d;
        end
    end

    // Payload storage; contents are don't-care until marked live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_q[wr_ptr_q] <= side_waddr;
            data_q[wr_ptr_q] <= side_wdata;
        end
    end

    // Write-port mux and status outputs; everything reads zero during reset.
    always_comb begin
        rf_we      = 1'b0;
        rf_waddr   = 5'd0;
        rf_wdata   = 32'd0;
        side_ready = ~rst & ~full;
        stallreq   = ~rst & (full | starved);
        pending    = rst ? '0 : count_q;
        if (!rst) begin
            if (wb_we) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (!empty && live_q[rd_ptr_q]) begin
                rf_we    = 1'b1;
                rf_waddr = addr_q[rd_ptr_q];
                rf_wdata = data_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed scenarios followed by random traffic,
// checked against a queue-based reference model through an expected queue.
module tb_rf_wport_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        side_valid;
    logic        side_ready;
    logic [4:0]  side_waddr;
    logic [31:0] side_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stallreq;
    logic [2:0]  pending;

    rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .side_valid (side_valid),
        .side_ready (side_ready),
        .side_waddr (side_waddr),
        .side_wdata (side_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .stallreq   (stallreq),
        .pending    (pending)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state: {rf_we, rf_waddr, rf_wdata, stallreq, pending, side_ready}
    localparam int W = 43;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model: side queue in arrival order, plus shadow regfiles
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;
    ent_t        mq[$];
    int          m_wait = 0;
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf   [32];

    // monitor: pops one expectation per cycle and compares settled outputs
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] g;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {rf_we, rf_waddr, rf_wdata, stallreq, pending, side_ready};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got we=%b a=%0d d=%h st=%b pend=%0d rdy=%b exp we=%b a=%0d d=%h st=%b pend=%0d rdy=%b",
                         $time, g[42], g[41:37], g[36:5], g[4], g[3:1], g[0],
                         e[42], e[41:37], e[36:5], e[4], e[3:1], e[0]);
            end
            if (rf_we === 1'b1) dut_rf[rf_waddr] = rf_wdata;
        end
    end

    // driver: applies one cycle of inputs, queues the expected response and
    // advances the model across the coming clock edge
    task automatic cycle(input bit r, input bit we, input logic [4:0] wa,
                         input logic [31:0] wd, input bit sv,
                         input logic [4:0] sa, input logic [31:0] sd);
        bit          e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        bit          rdy;
        bit          popped;
        int          n;
        rst = r; wb_we = we; wb_waddr = wa; wb_wdata = wd;
        side_valid = sv; side_waddr = sa; side_wdata = sd;
        n = mq.size();
        e_we = 1'b0; e_a = '0; e_d = '0; popped = 1'b0;
        if (r) begin
            exp_q.push_back('0);
            mq.delete();
            m_wait = 0;
        end else begin
            rdy = (n != DEPTH);
            if (we) begin
                e_we = 1'b1; e_a = wa; e_d = wd;
            end else if (n != 0) begin
                popped = 1'b1;
                if (mq[0].live) begin
                    e_we = 1'b1; e_a = mq[0].a; e_d = mq[0].d;
                end
            end
            exp_q.push_back({e_we, e_a, e_d,
                             (n == DEPTH) || (m_wait == STARVE_LIMIT),
                             3'(n), rdy});
            if (e_we) model_rf[e_a] = e_d;
            // head waiting time: counts cycles a non-empty queue goes undrained
            if (popped || n == 0) m_wait = 0;
            else if (m_wait < STARVE_LIMIT) m_wait++;
            if (we) begin
                foreach (mq[i]) if (mq[i].a == wa) mq[i].live = 1'b0;
            end
            if (popped) void'(mq.pop_front());
            if (sv && rdy && sa != 5'd0) mq.push_back('{a: sa, d: sd, live: 1'b1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = '0;
            dut_rf[i]   = '0;
        end
        rst = 1'b1; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        side_valid = 0; side_waddr = 0; side_wdata = 0;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);

        // WB only
        for (int i = 0; i < 3; i++) cycle(0, 1, 5'd5, 32'h11, 0, 0, 0);

        // single side result drains one cycle after accept
        cycle(0, 0, 0, 0, 1, 5'd3, 32'hDEAD);
        idle(2);

        // fill the queue behind continuous WB traffic, then drain in order
        for (int i = 0; i < 4; i++) cycle(0, 1, 5'd9, 32'h900 + i, 1, 5'(10 + i), 32'hA0 + i);
        cycle(0, 1, 5'd9, 32'h999, 1, 5'd20, 32'hBAD);
        cycle(0, 1, 5'd9, 32'h998, 0, 0, 0);
        idle(5);

        // starvation of a single entry
        cycle(0, 1, 5'd1, 32'h1, 1, 5'd4, 32'h44);
        for (int i = 0; i < 9; i++) cycle(0, 1, 5'd1, 32'h100 + i, 0, 0, 0);
        idle(2);

        // ordering: younger WB write supersedes the queued result
        cycle(0, 0, 0, 0, 1, 5'd7, 32'h1);
        cycle(0, 1, 5'd7, 32'h2, 0, 0, 0);
        idle(2);
        cycle(0, 0, 0, 0, 1, 5'd0, 32'hFFFF);
        idle(2);
        checks++;
        if (dut_rf[7] !== 32'h2) begin
            errors++;
            $display("FAIL r7_after_ordering got=%h exp=%h", dut_rf[7], 32'h2);
        end
        // same-cycle enqueue and WB write to one address keeps the new entry
        cycle(0, 1, 5'd6, 32'h60, 1, 5'd6, 32'h61);
        idle(2);

        // reset with three entries queued
        for (int i = 0; i < 3; i++) cycle(0, 1, 5'd2, 32'h20, 1, 5'(21 + i), 32'h77);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // random traffic in phases of differing WB load
        for (int ph = 0; ph < 40; ph++) begin
            int wb_pct;
            case ($urandom_range(0, 2))
                0:       wb_pct = 20;
                1:       wb_pct = 60;
                default: wb_pct = 95;
            endcase
            for (int i = 0; i < 50; i++) begin
                cycle(($urandom_range(0, 299) == 0),
                      ($urandom_range(0, 99) < wb_pct),
                      5'($urandom_range(0, 7)), $urandom,
                      ($urandom_range(0, 1) == 1),
                      5'($urandom_range(0, 7)), $urandom);
            end
        end
        idle(8);

        // let the monitor consume what remains, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_scoreboard left=%0d exp=0", exp_q.size());
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_rf[i] !== model_rf[i]) begin
                errors++;
                $display("FAIL regfile r%0d got=%h exp=%h", i, dut_rf[i], model_rf[i]);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
